// File: rtl/delay_scheduler_pkg.sv
// Shared types for the delay scheduler: FSM state encoding and the queued request layout.
package delay_sched_pkg;

    localparam int ENTRY_DELAY_W = 8;
    localparam int ENTRY_TAG_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

    // Field order matches the {delay, tag} packing stored in the request queue.
    typedef struct packed {
        logic [ENTRY_DELAY_W-1:0] delay;
        logic [ENTRY_TAG_W-1:0]   tag;
    } req_entry_t;

endpackage

// File: rtl/delay_scheduler_if.sv
// Request, counter-control and completion signals of the delay scheduler.
// master = requester/counter side, slave = scheduler.
interface delay_scheduler_if #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 2
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_delay;
    logic [TAG_W-1:0] req_tag;
    logic             tick;
    logic [WIDTH-1:0] cnt_x;
    logic             cnt_load;
    logic             cnt_en;
    logic [WIDTH-1:0] cnt_y;
    logic             done_valid;
    logic [TAG_W-1:0] done_tag;
    logic             busy;

    modport master (
        output req_valid, req_delay, req_tag, tick, cnt_y,
        input  req_ready, cnt_x, cnt_load, cnt_en, done_valid, done_tag, busy
    );

    modport slave (
        input  req_valid, req_delay, req_tag, tick, cnt_y,
        output req_ready, cnt_x, cnt_load, cnt_en, done_valid, done_tag, busy
    );
endinterface

// File: rtl/delay_req_fifo.sv
// Request queue: DEPTH-entry circular buffer; pointers carry a wrap bit to tell full from empty.
// Zero-latency head read; push ignored when full, pop ignored when empty.
module delay_req_fifo #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/delay_scheduler.sv
// Queues {delay, tag} requests and runs each through an external count-to-zero counter; DELAY_SCHEDULER_ABORT_EN adds an abort input.
// Done pulses D+4 cycles after accept into an idle block with tick high; req_ready drops only when the queue is full.
module delay_scheduler
    import delay_sched_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int TAG_W = 2
) (
    input  logic             clk,
    input  logic             reset,
`ifdef DELAY_SCHEDULER_ABORT_EN
    input  logic             abort,
`endif
    delay_scheduler_if.slave sif
);
    sched_state_t             state;
    sched_state_t             state_nxt;
    logic [WIDTH+TAG_W-1:0]   head;
    logic [WIDTH-1:0]         head_delay;
    logic [TAG_W-1:0]         head_tag;
    logic                     q_full;
    logic                     q_empty;
    logic                     push;
    logic                     pop;
    logic [TAG_W-1:0]         act_tag;
    logic [WIDTH-1:0]         cnt_x_q;
    logic                     load;
    logic                     en;
    logic                     done;

    // Ready is masked by reset directly so it is low throughout reset and high the cycle it releases.
    assign sif.req_ready = !q_full && !reset;
    assign push          = sif.req_valid && sif.req_ready;
    assign pop           = (state == ST_IDLE) && !q_empty;
    assign head_delay    = head[WIDTH+TAG_W-1:TAG_W];
    assign head_tag      = head[TAG_W-1:0];

    delay_req_fifo #(
        .DATA_W (WIDTH + TAG_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({sif.req_delay, sif.req_tag}),
        .pop       (pop),
        .pop_data  (head),
        .full      (q_full),
        .empty     (q_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            act_tag <= '0;
            cnt_x_q <= '0;
        end else begin
            state <= state_nxt;
            // Negated delay is captured at pop so it is already stable during LOAD.
            if (pop) begin
                act_tag <= head_tag;
                cnt_x_q <= -head_delay;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        en        = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!q_empty) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                load      = 1'b1;
                state_nxt = ST_COUNT;
            end
            ST_COUNT: begin
                // Counting stops at zero so the counter never wraps past it.
                if (sif.cnt_y == '0) state_nxt = ST_DONE;
                else                 en        = sif.tick;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
`ifdef DELAY_SCHEDULER_ABORT_EN
        if (abort && (state == ST_LOAD || state == ST_COUNT)) begin
            state_nxt = ST_IDLE;
            load      = 1'b0;
            en        = 1'b0;
        end
`endif
    end

    assign sif.cnt_x      = cnt_x_q;
    assign sif.cnt_load   = load;
    assign sif.cnt_en     = en;
    assign sif.done_valid = done;
    assign sif.done_tag   = done ? act_tag : '0;
    assign sif.busy       = (state != ST_IDLE) || !q_empty;

endmodule

// File: tb/tb_delay_scheduler.sv
// Bench for delay_scheduler: directed vector table, scoreboard-checked random traffic, reset and abort sequences.
module tb_delay_scheduler;
    import delay_sched_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int TAG_W = 2;

    logic clk = 1'b0;
    logic reset;
`ifdef DELAY_SCHEDULER_ABORT_EN
    logic abort;
`endif
    logic [WIDTH-1:0] cnt_model;

    int checks = 0;
    int errors = 0;

    delay_scheduler_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) sif ();

    delay_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef DELAY_SCHEDULER_ABORT_EN
        .abort (abort),
`endif
        .sif   (sif)
    );

    always #5 clk = ~clk;

    // Downstream count-to-zero counter: load x, then increment toward zero on en.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)             cnt_model <= '0;
        else if (sif.cnt_load) cnt_model <= sif.cnt_x;
        else if (sif.cnt_en)   cnt_model <= cnt_model + 1'b1;
    end
    assign sif.cnt_y = cnt_model;

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish (errors so far %0d)", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_ready"}, sif.req_ready, 0);
        check({pfx, "_busy"}, sif.busy, 0);
        check({pfx, "_load"}, sif.cnt_load, 0);
        check({pfx, "_en"}, sif.cnt_en, 0);
        check({pfx, "_cnt_x"}, sif.cnt_x, 0);
        check({pfx, "_done"}, sif.done_valid, 0);
        check({pfx, "_done_tag"}, sif.done_tag, 0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [WIDTH-1:0] delay;
        logic [TAG_W-1:0] tag;
        bit               alt_tick;
        logic [WIDTH-1:0] exp_x;
        int               exp_lat;
        bit               exp_en;
    } vec_t;

    vec_t vecs[5];

    // Entered and left at #1 after a rising edge with the block idle.
    task automatic run_vec(input int idx, input vec_t v);
        int               lat;
        int               loads;
        bit               en_seen;
        bit               both;
        logic [WIDTH-1:0] x_seen;
        logic [TAG_W-1:0] tag_seen;
        lat = -1; loads = 0; en_seen = 0; both = 0; x_seen = '0; tag_seen = '0;
        sif.req_valid = 1'b1;
        sif.req_delay = v.delay;
        sif.req_tag   = v.tag;
        sif.tick      = 1'b1;
        @(negedge clk);
        check($sformatf("vec%0d_ready", idx), sif.req_ready, 1);
        @(posedge clk); #1;
        sif.req_valid = 1'b0;
        for (int k = 1; k <= 300 && lat < 0; k++) begin
            sif.tick = v.alt_tick ? (k % 2 == 0) : 1'b1;
            @(negedge clk);
            if (sif.cnt_load) begin loads++; x_seen = sif.cnt_x; end
            if (sif.cnt_en) en_seen = 1'b1;
            if (sif.cnt_load && sif.cnt_en) both = 1'b1;
            if (sif.done_valid) begin lat = k; tag_seen = sif.done_tag; end
            @(posedge clk); #1;
        end
        check($sformatf("vec%0d_latency", idx), lat, v.exp_lat);
        check($sformatf("vec%0d_tag", idx), tag_seen, v.tag);
        check($sformatf("vec%0d_cnt_x", idx), x_seen, v.exp_x);
        check($sformatf("vec%0d_loads", idx), loads, 1);
        check($sformatf("vec%0d_en_seen", idx), en_seen, v.exp_en);
        check($sformatf("vec%0d_load_and_en", idx), both, 0);
        @(negedge clk);
        check($sformatf("vec%0d_pulse_end", idx), sif.done_valid, 0);
        check($sformatf("vec%0d_idle", idx), sif.busy, 0);
        @(posedge clk); #1;
    endtask

    // ---------------- timestamp reference model ----------------
    // Each request: popped in the first cycle the block is free and it heads the queue,
    // counting starts two cycles later, finishes one cycle after D ticks have been seen.
    req_entry_t mq[$];
    bit         m_act;
    req_entry_t m_cur;
    int         m_first;
    int         m_done;
    int         m_ticks;
    int         mcyc;

    task automatic model_reset();
        mq.delete();
        m_act = 1'b0; m_first = 0; m_done = -1; m_ticks = 0; mcyc = 0;
    endtask

    // mode 0: random traffic, 1: burst of 6 delay-10 requests, 2: drain
    task automatic run_model(input int ncyc, input int mode, output int n_done, output int n_rdy_low);
        bit               e_ready, e_done, e_load, e_en, e_busy, idle_now;
        logic [WIDTH-1:0] nx;
        req_entry_t       ent;
        int               pushed;
        pushed = 0; n_done = 0; n_rdy_low = 0;
        for (int i = 0; i < ncyc; i++) begin
            case (mode)
                0: begin
                    sif.req_valid = ($urandom_range(0, 1) == 1);
                    sif.req_delay = WIDTH'($urandom_range(0, 12));
                    sif.req_tag   = TAG_W'($urandom_range(0, 3));
                    sif.tick      = ($urandom_range(0, 3) != 0);
                end
                1: begin
                    sif.req_valid = (pushed < 6);
                    sif.req_delay = WIDTH'(10);
                    sif.req_tag   = TAG_W'(pushed);
                    sif.tick      = 1'b1;
                end
                default: begin
                    sif.req_valid = 1'b0;
                    sif.tick      = 1'b1;
                end
            endcase
            @(negedge clk);
            e_ready = (mq.size() < DEPTH);
            e_done  = m_act && (mcyc == m_done);
            e_load  = m_act && (mcyc == m_first - 1);
            e_en    = m_act && (mcyc >= m_first) && (mcyc != m_done)
                      && (m_ticks != int'(m_cur.delay)) && sif.tick;
            e_busy  = m_act || (mq.size() != 0);
            check("m_ready", sif.req_ready, e_ready);
            check("m_done_valid", sif.done_valid, e_done);
            check("m_busy", sif.busy, e_busy);
            check("m_cnt_load", sif.cnt_load, e_load);
            check("m_cnt_en", sif.cnt_en, e_en);
            if (e_done) check("m_done_tag", sif.done_tag, m_cur.tag);
            if (e_load) begin
                nx = '0 - m_cur.delay;
                check("m_cnt_x", sif.cnt_x, nx);
            end
            if (sif.done_valid) n_done++;
            if (!sif.req_ready) n_rdy_low++;

            idle_now = !m_act;
            if (m_act) begin
                if (mcyc == m_done) m_act = 1'b0;
                else if (mcyc >= m_first && m_done < 0) begin
                    if (m_ticks == int'(m_cur.delay)) m_done = mcyc + 1;
                    else if (sif.tick)                m_ticks++;
                end
            end
            if (idle_now && mq.size() != 0) begin
                m_cur   = mq.pop_front();
                m_act   = 1'b1;
                m_first = mcyc + 2;
                m_ticks = 0;
                m_done  = -1;
            end
            if (sif.req_valid && e_ready) begin
                ent.delay = sif.req_delay;
                ent.tag   = sif.req_tag;
                mq.push_back(ent);
                pushed++;
            end
            mcyc++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int n_done, n_rdy_low, n_tag1, lat2;

        reset = 1'b1;
        sif.req_valid = 1'b0;
        sif.req_delay = '0;
        sif.req_tag   = '0;
        sif.tick      = 1'b0;
`ifdef DELAY_SCHEDULER_ABORT_EN
        abort = 1'b0;
`endif
        vecs[0] = '{delay: 8'd5,   tag: 2'd1, alt_tick: 1'b0, exp_x: 8'hFB, exp_lat: 9,   exp_en: 1'b1};
        vecs[1] = '{delay: 8'd0,   tag: 2'd2, alt_tick: 1'b0, exp_x: 8'h00, exp_lat: 4,   exp_en: 1'b0};
        vecs[2] = '{delay: 8'd128, tag: 2'd3, alt_tick: 1'b0, exp_x: 8'h80, exp_lat: 132, exp_en: 1'b1};
        vecs[3] = '{delay: 8'd1,   tag: 2'd0, alt_tick: 1'b0, exp_x: 8'hFF, exp_lat: 5,   exp_en: 1'b1};
        vecs[4] = '{delay: 8'd3,   tag: 2'd1, alt_tick: 1'b1, exp_x: 8'hFD, exp_lat: 10,  exp_en: 1'b1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rel_ready", sif.req_ready, 1);
        check("rel_busy", sif.busy, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // Six back-to-back pushes: the queue fills and the last one waits for a slot.
        model_reset();
        run_model(120, 1, n_done, n_rdy_low);
        check("burst_done_count", n_done, 6);
        check("burst_saw_full", (n_rdy_low > 0), 1);

        run_model(400, 0, n_done, n_rdy_low);
        run_model(150, 2, n_done, n_rdy_low);
        check("drain_idle", sif.busy, 0);

`ifdef DELAY_SCHEDULER_ABORT_EN
        sif.tick = 1'b1;
        sif.req_valid = 1'b1; sif.req_delay = 8'd20; sif.req_tag = 2'd1;
        @(posedge clk); #1;
        sif.req_delay = 8'd2; sif.req_tag = 2'd2;
        @(posedge clk); #1;
        sif.req_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        n_tag1 = 0; lat2 = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("abort_load", sif.cnt_load, 0);
                check("abort_en", sif.cnt_en, 0);
            end
            if (sif.done_valid && sif.done_tag == 2'd1) n_tag1++;
            if (sif.done_valid && sif.done_tag == 2'd2 && lat2 < 0) lat2 = k;
            @(posedge clk); #1;
        end
        check("abort_no_done", n_tag1, 0);
        check("abort_next_lat", lat2, 6);
`endif

        // Reset during COUNT with two requests still queued.
        sif.tick = 1'b1;
        sif.req_valid = 1'b1; sif.req_delay = 8'd10;
        for (int k = 0; k < 3; k++) begin
            sif.req_tag = TAG_W'(k);
            @(posedge clk); #1;
        end
        sif.req_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        @(negedge clk);
        check("prerst_busy", sif.busy, 1);
        check("prerst_en", sif.cnt_en, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("midrst");
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("postrst_ready", sif.req_ready, 1);
        check("postrst_busy", sif.busy, 0);
        n_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (sif.done_valid) n_done++;
        end
        check("postrst_no_done", n_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
